// File: rtl/seg_scan_controller_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner.
// Glyphs are active-low, bit 0 = segment a through bit 6 = segment g.
package seg_scan_controller_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_PHASES = 8;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);
    localparam int PHASE_W    = $clog2(NUM_PHASES);

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    localparam logic [NUM_DIGITS-1:0] AN_OFF   = 4'b1111;
    localparam logic [6:0]            SSEG_OFF = 7'b1111111;

    // Active-low anode select: only the addressed digit's bit is low.
    function automatic logic [NUM_DIGITS-1:0] one_cold(input logic [DIGIT_W-1:0] d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg_scan_controller_hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_sseg
    import seg_scan_controller_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SSEG_OFF;
        case (hex)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SSEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit hex display scanner with PWM brightness, blanking, leading-zero
// suppression and a double-buffered value that commits only at frame end.
module seg_scan_controller
    import seg_scan_controller_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           value,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] blank,
    input  logic                  lzs,
    input  logic [2:0]            brightness,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            sseg,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] COUNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]           count;
    logic [PHASE_W-1:0]      phase;
    logic [DIGIT_W-1:0]      digit;
    logic [15:0]             active;
    logic [15:0]             pend_buf;
    logic                    tick;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   suppress;
    logic                    lit;
    logic [6:0]              glyph;

    assign tick      = (count == COUNT_MAX);
    assign frame_end = tick && (digit == DIGIT_W'(NUM_DIGITS - 1))
                            && (phase == PHASE_W'(NUM_PHASES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            phase <= '0;
            digit <= '0;
        end else if (tick) begin
            count <= '0;
            phase <= phase + 1'b1;
            if (phase == PHASE_W'(NUM_PHASES - 1))
                digit <= digit + 1'b1;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A load on the commit tick still lets the previous pending value commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= '0;
            pend_buf   <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end && pending)
                active <= pend_buf;
            if (load) begin
                pend_buf <= value;
                pending  <= 1'b1;
            end else if (frame_end) begin
                pending  <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sup
            if (gi == 0) begin : g_first
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = lzs && (active[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    assign lit = (phase <= brightness) && !blank[digit] && !suppress[digit];

    hex_to_sseg u_hex (
        .hex (active[{digit, 2'b00} +: 4]),
        .seg (glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= AN_OFF;
            sseg <= SSEG_OFF;
        end else if (lit) begin
            an   <= one_cold(digit);
            sseg <= glyph;
        end else begin
            an   <= AN_OFF;
            sseg <= SSEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller at REFRESH_DIV=2: table-driven slot checks,
// directed corner sequences and a per-cycle scoreboard against a timeline model.
module tb_seg_scan_controller;

    localparam int DIV   = 2;
    localparam int FRAME = DIV * 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank;
    logic        lzs;
    logic [2:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        pending;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    // Model: position derived from edges since reset release.
    int          n;
    int          last_d, last_p;
    logic [15:0] m_active, m_pbuf;
    bit          m_pend;
    logic [6:0]  glyph_tab [16];

    seg_scan_controller #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .blank      (blank),
        .lzs        (lzs),
        .brightness (brightness),
        .an         (an),
        .sseg       (sseg),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic step();
        logic [3:0] ean;
        logic [6:0] esg;
        bit         fe, lit;
        int         d, p, ticks;
        @(posedge clk);
        if (reset) begin
            m_active = '0; m_pbuf = '0; m_pend = 0; n = 0;
            last_d = -1; last_p = -1;
            ean = 4'hF; esg = 7'h7F; fe = 0;
        end else begin
            ticks = n / DIV;
            p = ticks % 8;
            d = (ticks / 8) % 4;
            fe = (n % FRAME) == FRAME - 1;
            lit = (p <= int'(brightness)) && !blank[d]
                  && !(lzs && d > 0 && (m_active >> (4*d)) == 16'h0);
            if (lit) begin
                ean = 4'hF;
                ean[d] = 1'b0;
                esg = glyph_tab[(m_active >> (4*d)) & 16'hF];
            end else begin
                ean = 4'hF; esg = 7'h7F;
            end
            last_d = d; last_p = p;
            if (fe && m_pend) m_active = m_pbuf;
            if (load) begin
                m_pbuf = value; m_pend = 1;
            end else if (fe) begin
                m_pend = 0;
            end
            n++;
        end
        #1;
        chk("sb_an", an, ean);
        chk("sb_sseg", sseg, esg);
        chk("sb_pending", pending, m_pend);
        chk("sb_frame_tick", frame_tick, fe);
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_slot(input int d, input int p);
        int k = 0;
        step();
        while (!(last_d == d && last_p == p) && k < 200) begin
            step();
            k++;
        end
        chk("slot_reached", (k < 200), 1);
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
        logic        lzs;
        logic [2:0]  brightness;
        int          d, p;
        logic [3:0]  exp_an;
        logic [6:0]  exp_sseg;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int cnt;
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        vecs[0]  = '{16'h1234, 4'b0000, 0, 3'd7, 0, 0, 4'b1110, 7'b0011001};
        vecs[1]  = '{16'h1234, 4'b0000, 0, 3'd7, 3, 3, 4'b0111, 7'b1111001};
        vecs[2]  = '{16'h00A0, 4'b0000, 1, 3'd7, 3, 0, 4'b1111, 7'b1111111};
        vecs[3]  = '{16'h00A0, 4'b0000, 1, 3'd7, 2, 0, 4'b1111, 7'b1111111};
        vecs[4]  = '{16'h00A0, 4'b0000, 1, 3'd7, 1, 0, 4'b1101, 7'b0001000};
        vecs[5]  = '{16'h00A0, 4'b0000, 1, 3'd7, 0, 5, 4'b1110, 7'b1000000};
        vecs[6]  = '{16'h1234, 4'b0000, 0, 3'd2, 1, 2, 4'b1101, 7'b0110000};
        vecs[7]  = '{16'h1234, 4'b0000, 0, 3'd2, 1, 3, 4'b1111, 7'b1111111};
        vecs[8]  = '{16'hFFFF, 4'b0100, 0, 3'd7, 2, 0, 4'b1111, 7'b1111111};
        vecs[9]  = '{16'hFFFF, 4'b0100, 0, 3'd7, 1, 0, 4'b1101, 7'b0001110};
        vecs[10] = '{16'hFFFF, 4'b0100, 0, 3'd7, 3, 7, 4'b0111, 7'b0001110};
        vecs[11] = '{16'h0000, 4'b0000, 0, 3'd7, 2, 0, 4'b1011, 7'b1000000};

        reset = 1'b1; value = '0; load = 1'b0; blank = '0; lzs = 1'b0; brightness = 3'd7;
        n = 0; last_d = -1; last_p = -1; m_active = '0; m_pbuf = '0; m_pend = 0;

        // Reset state and pre-commit display of the all-zero active buffer
        #2;
        chk("rst_async_an", an, 4'hF);
        step();
        chk("rst_an", an, 4'b1111);
        chk("rst_sseg", sseg, 7'b1111111);
        chk("rst_pending", pending, 0);
        reset = 1'b0;
        wait_slot(2, 0);
        chk("precommit_an", an, 4'b1011);
        chk("precommit_sseg", sseg, 7'b1000000);

        // pending holds until frame_tick, then drops together with it
        do_reset();
        value = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        cnt = 0;
        while (!frame_tick && cnt < 100) begin
            chk("pend_hold", pending, 1);
            step();
            cnt++;
        end
        chk("frame_tick_seen", frame_tick, 1);
        chk("pend_drop", pending, 0);

        // Table: commit a value, then inspect one scan slot
        foreach (vecs[i]) begin
            do_reset();
            blank = vecs[i].blank; lzs = vecs[i].lzs; brightness = vecs[i].brightness;
            value = vecs[i].value; load = 1'b1;
            step();
            load = 1'b0;
            repeat (FRAME - 1) step();
            wait_slot(vecs[i].d, vecs[i].p);
            chk($sformatf("vec%0d_an", i), an, vecs[i].exp_an);
            chk($sformatf("vec%0d_sseg", i), sseg, vecs[i].exp_sseg);
        end

        // Brightness 2: digit 1 lit for exactly 3 phases = 6 clocks of its slot
        do_reset();
        blank = '0; lzs = 1'b0; brightness = 3'd2;
        wait_slot(0, 7);
        step();
        cnt = 0;
        repeat (8*DIV) begin
            if (an == 4'b1101) cnt++;
            step();
        end
        chk("bright2_on_cycles", cnt, 3*DIV);

        // Load on the commit tick: old commits, new stays pending
        do_reset();
        brightness = 3'd7;
        value = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        while ((n % FRAME) != FRAME - 1) step();
        value = 16'h6666; load = 1'b1;
        step();
        load = 1'b0;
        chk("collide_pending", pending, 1);
        chk("collide_frame_tick", frame_tick, 1);
        wait_slot(0, 0);
        chk("collide_active5", sseg, 7'b0010010);
        chk("collide_pending_hold", pending, 1);
        while ((n % FRAME) != FRAME - 1) step();
        step();
        chk("second_commit_pending", pending, 0);
        wait_slot(0, 0);
        chk("second_commit_active6", sseg, 7'b0000010);

        // Randomized traffic against the scoreboard, with occasional resets
        do_reset();
        repeat (2500) begin
            value      = 16'($urandom);
            load       = ($urandom_range(0, 19) == 0);
            blank      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            lzs        = 1'($urandom);
            brightness = 3'($urandom);
            reset      = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
